// File: rtl/q_readout_pkg.sv
// Shared constants and the event record for the Q readout path.
package q_readout_pkg;

  localparam int Q_WIDTH        = 31;
  localparam int TS_WIDTH_DEF   = 32;
  localparam int DROP_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 16;

  typedef struct packed {
    logic                    lost;
    logic [TS_WIDTH_DEF-1:0] ts;
    logic [Q_WIDTH-1:0]      q;
  } q_event_t;

endpackage

// File: rtl/q_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with wrap-bit pointers.
module q_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the output is masked while empty, so stale
  // contents are never visible and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/q_event_buffer.sv
// Timestamped event buffer after Q_extractor with overflow accounting.
// Optional: define QBUF_TSTAMP_EN to build the timestamp counter and ts storage.
module q_event_buffer #(
  parameter  int DEPTH      = q_readout_pkg::DEPTH_DEF,
  parameter  int Q_WIDTH    = q_readout_pkg::Q_WIDTH,
  parameter  int TS_WIDTH   = q_readout_pkg::TS_WIDTH_DEF,
  parameter  int DROP_WIDTH = q_readout_pkg::DROP_WIDTH_DEF,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  q_valid_in,
  input  logic [Q_WIDTH-1:0]    q_in,
  input  logic                  clear_in,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [Q_WIDTH-1:0]    ev_q,
  output logic [TS_WIDTH-1:0]   ev_ts,
  output logic                  ev_lost,
  output logic [LW-1:0]         fill_level,
  output logic [DROP_WIDTH-1:0] drop_count,
  output logic                  overflow
);

`ifdef QBUF_TSTAMP_EN
  localparam int EW = 1 + TS_WIDTH + Q_WIDTH;
`else
  localparam int EW = 1 + Q_WIDTH;
`endif

  logic [EW-1:0] wr_data;
  logic [EW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          do_pop;
  logic          drop;
  logic          lost_pending;

  // Clear voids both sides of the handshake for its cycle.
  assign push_req = q_valid_in && !clear_in;
  assign do_pop   = ev_valid && ev_ready && !clear_in;
  assign drop     = push_req && full && !do_pop;
  assign ev_valid = !empty;

`ifdef QBUF_TSTAMP_EN
  logic [TS_WIDTH-1:0] ts;

  // Free-running; clear_in deliberately leaves the time base alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts + 1'b1;
  end

  assign wr_data = {lost_pending, ts, q_in};
  assign ev_ts   = rd_data[Q_WIDTH +: TS_WIDTH];
`else
  assign wr_data = {lost_pending, q_in};
  assign ev_ts   = '0;
`endif

  assign ev_q    = rd_data[Q_WIDTH-1:0];
  assign ev_lost = rd_data[EW-1];

  q_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_in),
    .push    (push_req),
    .pop     (do_pop),
    .din     (wr_data),
    .dout    (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fill_level)
  );

  // lost_pending marks the next accepted event so readout can see the gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count   <= '0;
      overflow     <= 1'b0;
      lost_pending <= 1'b0;
    end else if (clear_in) begin
      drop_count   <= '0;
      overflow     <= 1'b0;
      lost_pending <= 1'b0;
    end else if (drop) begin
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
      overflow     <= 1'b1;
      lost_pending <= 1'b1;
    end else if (push_req) begin
      lost_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_q_event_buffer.sv
// Self-checking bench for q_event_buffer: scoreboard plus table-driven vectors.
module tb_q_event_buffer;
  import q_readout_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        q_valid_in = 1'b0;
  logic [30:0] q_in = '0;
  logic        clear_in = 1'b0;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic [30:0] ev_q;
  logic [31:0] ev_ts;
  logic        ev_lost;
  logic [4:0]  fill_level;
  logic [15:0] drop_count;
  logic        overflow;

  logic        w_qv = 1'b0;
  logic [30:0] w_q = '0;
  logic        w_rdy = 1'b0;
  logic        w_valid;
  logic [30:0] w_ev_q;
  logic [3:0]  w_ev_ts;
  logic        w_lost;
  logic [2:0]  w_fill;
  logic [3:0]  w_drop;
  logic        w_ovf;

  always #5 clk = ~clk;

  q_event_buffer dut (
    .clk (clk), .reset_n (reset_n), .q_valid_in (q_valid_in), .q_in (q_in),
    .clear_in (clear_in), .ev_valid (ev_valid), .ev_ready (ev_ready),
    .ev_q (ev_q), .ev_ts (ev_ts), .ev_lost (ev_lost), .fill_level (fill_level),
    .drop_count (drop_count), .overflow (overflow)
  );

  // Narrow instance to reach timestamp wrap and drop saturation quickly.
  q_event_buffer #(.DEPTH (4), .TS_WIDTH (4), .DROP_WIDTH (4)) u_wrap (
    .clk (clk), .reset_n (reset_n), .q_valid_in (w_qv), .q_in (w_q),
    .clear_in (1'b0), .ev_valid (w_valid), .ev_ready (w_rdy),
    .ev_q (w_ev_q), .ev_ts (w_ev_ts), .ev_lost (w_lost), .fill_level (w_fill),
    .drop_count (w_drop), .overflow (w_ovf)
  );

  // Reference time base: value the DUT sees at the next rising edge.
  logic [31:0] tb_ts;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 1;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  q_event_t    sb[$];
  logic        m_lost_pend = 1'b0;
  logic [15:0] m_drop = '0;
  logic        m_ovf = 1'b0;
  logic [30:0] last_pop = '0;

  typedef struct {
    logic        qv;
    logic [30:0] q0;
    logic        rdy;
    logic        clr;
    int          n;
    logic [4:0]  fill;
    logic [15:0] drop;
    logic        ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_ts(input logic [31:0] t);
`ifdef QBUF_TSTAMP_EN
    return t;
`else
    return 32'd0 & t;
`endif
  endfunction

  // Called at a falling edge: compare outputs, drive inputs, advance the model.
  task automatic step(input logic qv, input logic [30:0] q, input logic rdy, input logic clr);
    q_event_t e;
    logic     pop;
    chk("ev_valid", ev_valid, sb.size() != 0);
    chk("fill_level", fill_level, sb.size());
    chk("drop_count", drop_count, m_drop);
    chk("overflow", overflow, m_ovf);
    if (sb.size() != 0) begin
      chk("ev_q", ev_q, sb[0].q);
      chk("ev_ts", ev_ts, sb[0].ts);
      chk("ev_lost", ev_lost, sb[0].lost);
    end
    q_valid_in = qv; q_in = q; ev_ready = rdy; clear_in = clr;
    pop = (sb.size() != 0) && rdy && !clr;
    if (clr) begin
      sb.delete();
      m_lost_pend = 1'b0;
      m_drop = '0;
      m_ovf = 1'b0;
    end else begin
      if (pop) begin
        e = sb.pop_front();
        last_pop = e.q;
      end
      if (qv) begin
        if (sb.size() < DEPTH) begin
          e.lost = m_lost_pend;
          e.ts = exp_ts(tb_ts);
          e.q = q;
          sb.push_back(e);
          m_lost_pend = 1'b0;
        end else begin
          if (m_drop != 16'hffff) m_drop = m_drop + 1;
          m_ovf = 1'b1;
          m_lost_pend = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 31'h01, 1'b0, 1'b0, 16, 5'd16, 16'd2 - 16'd2, 1'b0};
    vecs[1]  = '{1'b1, 31'h11, 1'b0, 1'b0,  2, 5'd16, 16'd2, 1'b1};
    vecs[2]  = '{1'b0, 31'h00, 1'b1, 1'b0, 16, 5'd0,  16'd2, 1'b1};
    vecs[3]  = '{1'b1, 31'h55, 1'b0, 1'b0,  1, 5'd1,  16'd2, 1'b1};
    vecs[4]  = '{1'b1, 31'h56, 1'b0, 1'b0,  1, 5'd2,  16'd2, 1'b1};
    vecs[5]  = '{1'b0, 31'h00, 1'b1, 1'b0,  2, 5'd0,  16'd2, 1'b1};
    vecs[6]  = '{1'b1, 31'h60, 1'b0, 1'b0, 16, 5'd16, 16'd2, 1'b1};
    vecs[7]  = '{1'b1, 31'h77, 1'b1, 1'b0,  1, 5'd16, 16'd2, 1'b1};
    vecs[8]  = '{1'b0, 31'h00, 1'b1, 1'b0, 16, 5'd0,  16'd2, 1'b1};
    vecs[9]  = '{1'b1, 31'h80, 1'b0, 1'b0,  5, 5'd5,  16'd2, 1'b1};
    vecs[10] = '{1'b1, 31'h99, 1'b1, 1'b1,  1, 5'd0,  16'd0, 1'b0};
    vecs[11] = '{1'b1, 31'hA0, 1'b0, 1'b0, 18, 5'd16, 16'd2, 1'b1};
    vecs[12] = '{1'b0, 31'h00, 1'b0, 1'b1,  1, 5'd0,  16'd0, 1'b0};
    vecs[13] = '{1'b1, 31'hC0, 1'b0, 1'b0,  1, 5'd1,  16'd0, 1'b0};
    vecs[14] = '{1'b0, 31'h00, 1'b1, 1'b0,  1, 5'd0,  16'd0, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_q", ev_q, 0);
    chk("rst_ev_ts", ev_ts, 0);
    chk("rst_ev_lost", ev_lost, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single event captured at ts=5, consumed on its first visible cycle.
    for (int i = 0; i < 20 && tb_ts != 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("t1_ts_reached", tb_ts, 5);
    step(1'b1, 31'h1234, 1'b1, 1'b0);
    chk("t1_valid", ev_valid, 1);
    chk("t1_q", ev_q, 31'h1234);
`ifdef QBUF_TSTAMP_EN
    chk("t1_ts", ev_ts, 5);
`else
    chk("t1_ts", ev_ts, 0);
`endif
    chk("t1_lost", ev_lost, 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t1_valid_gone", ev_valid, 0);
    chk("t1_fill_zero", fill_level, 0);

    // Table: overflow, drain order, lost marking, full push+pop, clear.
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < vecs[i].n; k++)
        step(vecs[i].qv, vecs[i].q0 + 31'(k), vecs[i].rdy, vecs[i].clr);
      q_valid_in = 1'b0; ev_ready = 1'b0; clear_in = 1'b0;
      chk($sformatf("vec%0d_fill", i), fill_level, vecs[i].fill);
      chk($sformatf("vec%0d_drop", i), drop_count, vecs[i].drop);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
      if (i == 3) chk("lost_after_drop", ev_lost, 1);
      if (i == 8) chk("push_pop_full_last", last_pop, 31'h77);
      if (i == 10) chk("clear_valid", ev_valid, 0);
    end

    // Reset mid-operation drops buffered events without counting them.
    step(1'b1, 31'h3, 1'b0, 1'b0);
    step(1'b1, 31'h4, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", ev_valid, 0);
    chk("midrst_fill", fill_level, 0);
    chk("midrst_drop", drop_count, 0);
    sb.delete();
    m_lost_pend = 1'b0; m_drop = '0; m_ovf = 1'b0;
    q_valid_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Narrow instance: timestamp wrap 15 -> 0, then drop saturation.
    for (int i = 0; i < 40 && tb_ts != 15; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("wrap_ts_reached", tb_ts, 15);
    w_qv = 1'b1; w_q = 31'h15;
    @(negedge clk);
    w_q = 31'h16;
    @(negedge clk);
    w_qv = 1'b0;
    chk("wrap_valid", w_valid, 1);
    chk("wrap_q0", w_ev_q, 31'h15);
`ifdef QBUF_TSTAMP_EN
    chk("wrap_ts15", w_ev_ts, 4'd15);
`else
    chk("wrap_ts15", w_ev_ts, 4'd0);
`endif
    w_rdy = 1'b1;
    @(negedge clk);
    w_rdy = 1'b0;
    chk("wrap_q1", w_ev_q, 31'h16);
    chk("wrap_ts0", w_ev_ts, 4'd0);
    chk("wrap_fill1", w_fill, 3'd1);
    w_qv = 1'b1;
    for (int k = 0; k < 24; k++) begin
      w_q = 31'h100 + 31'(k);
      @(negedge clk);
    end
    w_qv = 1'b0;
    chk("sat_fill", w_fill, 3'd4);
    chk("sat_drop", w_drop, 4'd15);
    chk("sat_ovf", w_ovf, 1);
    chk("sat_head_lost", w_lost, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
